sha_dbl_sched: RTL

//  Job scheduler for the shared SHA-256 core. Feeds host message words to the core in 16-word blocks.

---
 rtl/sha_pkg.sv | 20 ++
 rtl/sha_dbl_sched.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 job scheduler.
// Block size, digest width and scheduler state encoding.
package sha_pkg;

    localparam int SHA_WPB   = 16;
    localparam int SHA_DIG_W = 256;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_HOST,
        ST_WAIT_H,
        ST_DINIT,
        ST_DREQ,
        ST_DBL,
        ST_WAIT_D,
        ST_RES
    } state_e;

endpackage

// File: rtl/sha_dbl_sched.sv
// SHA-256 job scheduler: feeds host blocks to the core, optionally
// chains a second pass from the double-SHA feeder, latches the digest.
module sha_dbl_sched
    import sha_pkg::*;
#(
    parameter int WPB   = SHA_WPB,
    parameter int TMO_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 cfg_auto_dbl,
    input  logic                 host_vld,
    input  logic [31:0]          host_din,
    input  logic                 host_last,
    output logic                 host_rdy,
    output logic                 core_init,
    output logic                 core_vld,
    output logic [31:0]          core_din,
    input  logic                 core_done,
    input  logic [SHA_DIG_W-1:0] core_hash,
    output logic                 dbl_start,
    input  logic                 dbl_vld,
    input  logic [31:0]          dbl_din,
    output logic                 busy,
    output logic                 res_vld,
    output logic [SHA_DIG_W-1:0] res_hash,
    output logic [1:0]           err
);

    localparam int CW = $clog2(WPB);
    localparam logic [CW-1:0] WLAST = CW'(WPB - 1);
    localparam logic [TMO_W-1:0] TMAX = {TMO_W{1'b1}};

    state_e               state_q, state_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 last_q, last_d;
    logic [SHA_DIG_W-1:0] res_q, res_d;
    logic [1:0]           err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            tmo_q   <= '0;
            last_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
            last_q  <= last_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        tmo_d     = tmo_q;
        last_d    = last_q;
        res_d     = res_q;
        err_d     = err_q;
        host_rdy  = 1'b0;
        core_init = 1'b0;
        core_vld  = 1'b0;
        core_din  = '0;
        dbl_start = 1'b0;
        res_vld   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (host_vld) state_d = ST_INIT;
            end
            ST_INIT: begin
                core_init = 1'b1;
                wcnt_d    = '0;
                state_d   = ST_HOST;
            end
            ST_HOST: begin
                host_rdy = 1'b1;
                if (host_vld) begin
                    // early host_last aborts without forwarding the word
                    if (host_last && wcnt_q != WLAST) begin
                        err_d[0] = 1'b1;
                        wcnt_d   = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        core_vld = 1'b1;
                        core_din = host_din;
                        if (wcnt_q == WLAST) begin
                            wcnt_d  = '0;
                            tmo_d   = '0;
                            last_d  = host_last;
                            state_d = ST_WAIT_H;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_H: begin
                tmo_d = tmo_q + 1'b1;
                if (core_done) begin
                    if (!last_q) begin
                        state_d = ST_HOST;
                    end else if (!cfg_auto_dbl) begin
                        res_d   = core_hash;
                        state_d = ST_RES;
                    end else begin
                        state_d = ST_DINIT;
                    end
                end else if (tmo_q == TMAX) begin
                    err_d[1] = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DINIT: begin
                core_init = 1'b1;
                state_d   = ST_DREQ;
            end
            ST_DREQ: begin
                dbl_start = 1'b1;
                wcnt_d    = '0;
                state_d   = ST_DBL;
            end
            ST_DBL: begin
                if (dbl_vld) begin
                    core_vld = 1'b1;
                    core_din = dbl_din;
                    if (wcnt_q == WLAST) begin
                        wcnt_d  = '0;
                        tmo_d   = '0;
                        state_d = ST_WAIT_D;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            ST_WAIT_D: begin
                tmo_d = tmo_q + 1'b1;
                if (core_done) begin
                    res_d   = core_hash;
                    state_d = ST_RES;
                end else if (tmo_q == TMAX) begin
                    err_d[1] = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_RES: begin
                res_vld = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // abort wins over everything, including this cycle's strobes
        if (clr) begin
            state_d   = ST_IDLE;
            wcnt_d    = '0;
            tmo_d     = '0;
            last_d    = 1'b0;
            res_d     = res_q;
            err_d     = '0;
            host_rdy  = 1'b0;
            core_init = 1'b0;
            core_vld  = 1'b0;
            core_din  = '0;
            dbl_start = 1'b0;
            res_vld   = 1'b0;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign res_hash = res_q;
    assign err      = err_q;

endmodule
